m_dm: RTL and testbench
=======================

Name: m_dm

Overview:
- Data memory for the M stage of the 5-stage pipeline. It sits directly upstream of the M/W pipeline register.
- Performs word, halfword and byte loads and stores on a word-organised RAM. Load data is sign- or zero-extended.
- Read path is combinational, so the M/W register captures M_dmrd in the same cycle. Writes commit on the clock edge.

Parameters:
- DEPTH_WORDS, 3072, number of 32-bit words.
- IDX_W, 12, word-index width; word index = M_addr[IDX_W+1:2].

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- M_pc  in  32  PC of the instruction in M; used for the write log
- M_re  in  1  load access active this cycle
- M_we  in  1  store access active this cycle
- M_op  in  3  width/extension: 0 word, 1 byte signed, 2 byte unsigned, 3 half signed, 4 half unsigned; 5-7 treated as 0
- M_addr  in  32  byte address (ALU result)
- M_wd  in  32  store data, right-aligned (bits [7:0] for sb, [15:0] for sh)
- M_dmrd  out  32  extended load data
- M_exc  out  1  access fault flag (see Optional Feature)

Behaviour:
- Storage: DEPTH_WORDS x 32 array.
- Reset: on posedge clk with reset=1, every word is cleared to 0 in that single edge. Any write in the same cycle is dropped; reset wins. After reset, M_dmrd=0 for every address.
- Index: idx = M_addr[IDX_W+1:2]. idx >= DEPTH_WORDS is out of range: writes are ignored and the read word is 0.
- Read, combinational: word = mem[idx].
  - Byte lane = M_addr[1:0].
  - Half lane = M_addr[1]; M_addr[0] is ignored.
  - op0: M_dmrd = word.
  - op1/op2: selected byte, sign-extended (op1) or zero-extended (op2).
  - op3/op4: selected half, sign-extended (op3) or zero-extended (op4).
  - M_dmrd is driven regardless of M_re; M_re only gates fault detection.
- Write, on posedge clk when M_we=1 and not reset:
  - Byte enables: op0 -> 4'b1111; op1/2 -> one-hot 1<<M_addr[1:0]; op3/4 -> M_addr[1] ? 4'b1100 : 4'b0011.
  - Data is replicated into the lanes: byte {4{wd[7:0]}}, half {2{wd[15:0]}}. Only enabled bytes change.
- Read-during-write, same cycle same word: M_dmrd shows the pre-write contents. The new value is visible from the next cycle.
- M_re and M_we both 1: both are performed; this is legal, with no priority needed.
- Write log: on every committed write, print $display("%d@%h: *%h <= %h", $time, M_pc, {M_addr[31:2],2'b00}, merged_word). merged_word is the full post-write word. There is no log on dropped or suppressed writes.
- Latency: load 0 cycles (combinational), store 1 edge.

Optional Feature:
- Macro DM_ALIGN_CHECK_EN.
- Defined:
  - M_exc=1 combinationally when (M_re|M_we) and any of the following holds: op0 with M_addr[1:0]!=0; op3/4 with M_addr[0]=1; idx out of range.
  - When M_exc=1 with M_we=1, the write is suppressed, with no memory change and no log.
  - M_dmrd is forced to 0 while M_exc=1 and M_re=1.
- Undefined:
  - M_exc is tied 0.
  - Misaligned low bits are silently ignored as described in Behaviour.
  - Out-of-range writes are still ignored.

Test Plan:
- Reset, then M_re=1 op0 addr 0x0000_0010 -> M_dmrd=0x0000_0000. Same result at addr 0x0000_2FFC.
- Store sw 0x8765_4321 at 0x04, then load op1 addr 0x07 -> 0xFFFF_FF87; op2 -> 0x0000_0087; op3 addr 0x06 -> 0xFFFF_8765; op4 addr 0x04 -> 0x0000_4321.
- Store sw 0x0 at 0x08, then sb 0xAA at 0x09, then sh 0xBEEF at 0x0A -> load op0 at 0x08 = 0xBEEF_AA00. Log shows 0x0000_AA00 then 0xBEEF_AA00.
- Same-cycle sw 0x1111_1111 and load at 0x0C, old contents 0x2222_2222 -> M_dmrd=0x2222_2222 that cycle, 0x1111_1111 next cycle.
- Assert reset together with sw at 0x10 -> word 0x10 reads 0 afterwards and no log line is printed. Also reset after several writes -> all previously written words read 0.
- With DM_ALIGN_CHECK_EN: sw at 0x0000_0006 -> M_exc=1, memory unchanged. Op3 load at 0x01 -> M_exc=1, M_dmrd=0. Sw at idx 3072 (addr 0x0000_3000) -> M_exc=1. Without the macro: M_exc=0 for all three, and the sw at 0x06 writes word 0x04.

Source files
------------

// File: rtl/m_dm.sv
// m_dm: M-stage data memory with sub-word loads/stores; DM_ALIGN_CHECK_EN enables fault detection and write suppression.
module m_dm #(
  parameter int DEPTH_WORDS = 3072,
  parameter int IDX_W = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_pc,
  input  logic        M_re,
  input  logic        M_we,
  input  logic [2:0]  M_op,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_wd,
  output logic [31:0] M_dmrd,
  output logic        M_exc
);
  logic [31:0] mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic        in_range;
  logic [2:0]  op;
  logic [31:0] word;
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] rd;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] merged;
  logic        do_write;
  assign idx = M_addr[IDX_W+1:2];
  assign in_range = 32'(idx) < DEPTH_WORDS;
  assign op = M_op > 3'd4 ? 3'd0 : M_op;
  assign word = in_range ? mem[idx] : '0;
  assign b = word[{M_addr[1:0], 3'b000} +: 8];
  assign h = M_addr[1] ? word[31:16] : word[15:0];
  always_comb begin
    rd = op == 3'd1 ? {{24{b[7]}}, b} :
         op == 3'd2 ? {24'b0, b} :
         op == 3'd3 ? {{16{h[15]}}, h} :
         op == 3'd4 ? {16'b0, h} : word;
    be = op == 3'd0 ? 4'b1111 :
         op <= 3'd2 ? 4'b0001 << M_addr[1:0] :
         M_addr[1] ? 4'b1100 : 4'b0011;
    wdata = op == 3'd0 ? M_wd : op <= 3'd2 ? {4{M_wd[7:0]}} : {2{M_wd[15:0]}};
    merged = word;
    for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : word[8*i +: 8];
  end
`ifdef DM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (op == 3'd0 && M_addr[1:0] != 2'b00) || ((op == 3'd3 || op == 3'd4) && M_addr[0]) || !in_range;
  assign M_exc = (M_re | M_we) & misaligned;
  assign M_dmrd = (M_exc & M_re) ? '0 : rd;
`else
  // without the check the access strobes have no effect on the outputs
  assign M_exc = (M_re | M_we) & 1'b0;
  assign M_dmrd = rd;
`endif
  assign do_write = M_we & in_range & ~M_exc;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (do_write) begin
      mem[idx] <= merged;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, M_pc, {M_addr[31:2], 2'b00}, merged);
`endif
    end
  end
endmodule

// File: tb/tb_m_dm.sv
// tb_m_dm: directed plus random checks of m_dm against a byte-addressed reference model.
module tb_m_dm;
  localparam int NBYTES = 4 * 3072;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] M_pc = 0;
  logic        M_re = 0;
  logic        M_we = 0;
  logic [2:0]  M_op = 0;
  logic [31:0] M_addr = 0;
  logic [31:0] M_wd = 0;
  logic [31:0] M_dmrd;
  logic        M_exc;
  int total = 0;
  int bad = 0;
  logic [7:0] mb [NBYTES];
  m_dm dut (
    .clk(clk), .reset(reset), .M_pc(M_pc), .M_re(M_re), .M_we(M_we), .M_op(M_op),
    .M_addr(M_addr), .M_wd(M_wd), .M_dmrd(M_dmrd), .M_exc(M_exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int eff(input logic [31:0] a);
    return int'(a[13:0]);
  endfunction
  function automatic logic [31:0] m_read(input logic [2:0] op, input logic [31:0] a);
    int e = eff(a);
    int w = e - e % 4;
    int hh = e - e % 2;
    int o = op > 4 ? 0 : int'(op);
    if (e >= NBYTES) return 0;
    case (o)
      1: return {{24{mb[e][7]}}, mb[e]};
      2: return {24'b0, mb[e]};
      3: return {{16{mb[hh+1][7]}}, mb[hh+1], mb[hh]};
      4: return {16'b0, mb[hh+1], mb[hh]};
      default: return {mb[w+3], mb[w+2], mb[w+1], mb[w]};
    endcase
  endfunction
  function automatic logic m_exc(input logic re, input logic we, input logic [2:0] op, input logic [31:0] a);
`ifdef DM_ALIGN_CHECK_EN
    int o = op > 4 ? 0 : int'(op);
    logic bad_a = (o == 0 && a % 4 != 0) || ((o == 3 || o == 4) && a % 2 != 0) || eff(a) >= NBYTES;
    return (re || we) && bad_a;
`else
    return 1'b0;
`endif
  endfunction
  task automatic m_write(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int e = eff(a);
    int o = op > 4 ? 0 : int'(op);
    if (e >= NBYTES) return;
    if (o == 0) for (int i = 0; i < 4; i++) mb[e - e % 4 + i] = wd[8*i +: 8];
    else if (o <= 2) mb[e] = wd[7:0];
    else begin
      mb[e - e % 2] = wd[7:0];
      mb[e - e % 2 + 1] = wd[15:8];
    end
  endtask
  task automatic m_clear();
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
  endtask
  task automatic do_op(input logic re, input logic we, input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    logic x;
    logic [31:0] e;
    M_re = re; M_we = we; M_op = op; M_addr = a; M_wd = wd; M_pc = M_pc + 4;
    #2;
    x = m_exc(re, we, op, a);
    e = (x && re) ? 32'h0 : m_read(op, a);
    chk("dmrd", M_dmrd, e);
    chk("exc", {31'b0, M_exc}, {31'b0, x});
    @(posedge clk);
    if (we && !x) m_write(op, a, wd);
    #1;
    M_re = 0; M_we = 0;
  endtask
  task automatic ld(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] exp);
    do_op(1, 0, op, a, 0);
    chk(tag, M_dmrd, exp);
  endtask
  task automatic do_reset(input logic we, input logic [31:0] a, input logic [31:0] wd);
    M_we = we; M_op = 0; M_addr = a; M_wd = wd; reset = 1;
    @(posedge clk);
    #1;
    reset = 0; M_we = 0;
    m_clear();
  endtask
  initial begin
    logic [31:0] ra;
    m_clear();
    @(posedge clk);
    #1;
    do_reset(0, 0, 0);
    ld("rst_10", 0, 32'h10, 32'h0);
    ld("rst_2ffc", 0, 32'h2FFC, 32'h0);
    do_op(0, 1, 0, 32'h04, 32'h8765_4321);
    ld("lb_07", 1, 32'h07, 32'hFFFF_FF87);
    ld("lbu_07", 2, 32'h07, 32'h0000_0087);
    ld("lh_06", 3, 32'h06, 32'hFFFF_8765);
    ld("lhu_04", 4, 32'h04, 32'h0000_4321);
    do_op(0, 1, 0, 32'h08, 32'h0);
    do_op(0, 1, 1, 32'h09, 32'h55AA);
    ld("merge_b", 0, 32'h08, 32'h0000_AA00);
    do_op(0, 1, 3, 32'h0A, 32'h1234_BEEF);
    ld("merge_h", 0, 32'h08, 32'hBEEF_AA00);
    do_op(0, 1, 0, 32'h0C, 32'h2222_2222);
    do_op(1, 1, 0, 32'h0C, 32'h1111_1111);
    ld("rdw_new", 0, 32'h0C, 32'h1111_1111);
    do_op(0, 1, 0, 32'h10, 32'hCAFE_F00D);
    do_reset(1, 32'h10, 32'h5A5A_5A5A);
    ld("rstw_10", 0, 32'h10, 32'h0);
    ld("rstw_04", 0, 32'h04, 32'h0);
    ld("rstw_08", 0, 32'h08, 32'h0);
    ld("rstw_0c", 0, 32'h0C, 32'h0);
    do_op(0, 1, 0, 32'h04, 32'h0BAD_0BAD);
    do_op(0, 1, 0, 32'h06, 32'hDEAD_BEEF);
    do_op(1, 0, 3, 32'h01, 32'h0);
    do_op(0, 1, 0, 32'h3000, 32'h7777_7777);
`ifdef DM_ALIGN_CHECK_EN
    ld("sw_mis_kept", 0, 32'h04, 32'h0BAD_0BAD);
`else
    ld("sw_mis_wrote", 0, 32'h04, 32'hDEAD_BEEF);
`endif
    ld("oor_read", 0, 32'h3000, 32'h0);
    for (int n = 0; n < 500; n++) begin
      case ($urandom_range(0, 9))
        0: ra = 32'h2FE0 + $urandom_range(0, 63);
        1: ra = $urandom;
        default: ra = $urandom_range(0, 63);
      endcase
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
    end
    for (int i = 0; i < 16; i++) do_op(1, 0, 0, 32'(4 * i), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
